h264_fwd_transform4x4: RTL and testbench
========================================

// Module: h264_fwd_transform4x4
// PURPOSE
//  Forward 4x4 integer core transform, W = C*X*C^T, with C rows [1 1 1 1] [2 1 -1 -2] [1 -1 -1 1] [1 -2 2 -1].
//  Sits directly downstream of the intra 4x4 predictor and consumes its 36-bit residual rows (4 x 9-bit signed).
//  Emits coefficient rows to the quantiser.
//  Double-buffered so that a whole sub-block is always accepted once its first row is accepted.
// PARAMETERS
//  IWIDTH  9   signed residual width per lane (DATAI = 4*IWIDTH)
//  OWIDTH  16  signed coefficient width per lane (DATAO = 4*OWIDTH); needs >= IWIDTH+6
// PORTS
//  CLK       in   1   clock, rising edge
//  RESETN    in   1   asynchronous, active-low reset
//  STROBEI   in   1   residual row valid
//  DATAI     in   36  residual row; [8:0]=col0 .. [35:27]=col3, signed two's complement
//  READYI    out  1   block-level ready: upstream may start a new 4-row block
//  VALIDO    out  1   coefficient row valid
//  DATAO     out  64  coefficient row k; [15:0]=col0 .. [63:48]=col3, signed
//  LASTO     out  1   high with row 3 of each block
//  READYO    in   1   downstream accepts DATAO when VALIDO&&READYO
//  NZCOUNTO  out  5   nonzero-coefficient count (only with H264_FT_NZCOUNT_EN)
// BEHAVIOUR
//  - Reset (async, RESETN=0): both banks empty, write/read row pointers=0, write/read bank=0.
//    VALIDO=0, LASTO=0, DATAO=0, NZCOUNTO=0. Takes effect immediately and discards any partial or buffered block.
//  - Row stage (combinational on DATAI): e=a+d, f=b+c, g=b-c, h=a-d.
//    R0=e+f, R1=2h+g, R2=e-f, R3=h-2g. Stored at 12 bits signed.
//  - On STROBEI at an edge:
//    - R is written to bank[wbank] row wrow, and wrow increments.
//    - At wrow=3 the bank is marked full, wbank toggles and wrow wraps to 0.
//  - READYI = (wrow!=0) || !full[wbank]. It only drops between blocks.
//    STROBEI while READYI=0 is a protocol error: the row is ignored and the bench asserts it.
//  - Column stage, from stored rows S0..S3 of bank[rbank]:
//    - W0 = S0+S1+S2+S3
//    - W1 = 2S0+S1-S2-2S3
//    - W2 = S0-S1-S2+S3
//    - W3 = S0-2S1+2S2-S3
//    - Sign-extended to OWIDTH; no saturation needed (|W| <= 9180).
//  - Output FSM states:
//    - IDLE: if full[rbank], load W0 into the DATAO register, VALIDO=1 -> OUT.
//    - OUT: when VALIDO&&READYO, advance rrow and load W(rrow+1). LASTO=(rrow==3).
//      - On the row-3 handshake: clear full[rbank], toggle rbank, rrow=0.
//      - Then go back to IDLE, or load W0 of the other bank in the same cycle if it is already full (no bubble).
//  - While VALIDO&&!READYO: DATAO, LASTO and NZCOUNTO hold stable.
//  - Latency:
//    - Row 3 of block accepted at edge E -> VALIDO with W0 after edge E+1.
//    - First-row-to-first-output is 5 edges.
//    - Throughput is 1 row/cycle sustained.
//  - Simultaneous events:
//    - A bank freed by the row-3 handshake is seen by READYI only from the next cycle.
//    - A write into one bank and a read from the other bank in the same cycle are independent.
//  - A write bank that fills in the same cycle the output FSM goes IDLE is picked up the following cycle.
// CONFIGURATION
//  - H264_FT_NZCOUNT_EN defined:
//    - While the column stage produces a block, count its nonzero coefficients into a 5-bit counter (0..16).
//    - NZCOUNTO presents the count, valid with the LASTO row and held until the next LASTO row.
//    - The count is used by CAVLC nC prediction.
//  - H264_FT_NZCOUNT_EN undefined: no NZCOUNTO port and no counter logic. All other behaviour is identical.
// TESTING
//  1 All-zero block (4 rows DATAI=0) -> 4 rows DATAO=0, LASTO on row 3, NZCOUNTO=0.
//  2 DC block: all residuals +5 -> row0=[80,0,0,0], rows1-3 all 0, NZCOUNTO=1.
//  3 Impulse: X[0][0]=1, rest 0 -> rows [1,2,1,1] [2,4,2,2] [1,2,1,1] [1,2,1,1], NZCOUNTO=16.
//  4 Extreme: X[i][j]=255*s[i]*s[j], s=[+,+,-,-] -> W[1][1]=9180, no overflow.
//    Negated block gives W[1][1]=-9180.
//  5 Backpressure: 3 blocks back-to-back, READYO=0 for 12 cycles.
//    -> Blocks 1 and 2 are buffered, READYI=0 before block 3 row0, DATAO held stable.
//    -> All 12 rows are delivered in order after release, with no bubbles between blocks.
//  6 RESETN low after row 2 of a block -> VALIDO/DATAO=0 at once.
//    The next full block after release is transformed correctly (re-run test 3).

Source files
------------

// File: rtl/h264_fwd_transform4x4.sv
// Double-buffered forward 4x4 H.264 core transform, one coefficient row per cycle.
// Define H264_FT_NZCOUNT_EN to add the per-block nonzero count output NZCOUNTO.
module h264_fwd_transform4x4 #(
    parameter int IWIDTH = 9,
    parameter int OWIDTH = 16
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic                STROBEI,
    input  logic [4*IWIDTH-1:0] DATAI,
    output logic                READYI,
    output logic                VALIDO,
    output logic [4*OWIDTH-1:0] DATAO,
    output logic                LASTO,
    input  logic                READYO
`ifdef H264_FT_NZCOUNT_EN
    ,
    output logic [4:0]          NZCOUNTO
`endif
);

    localparam int RW = IWIDTH + 3;

    typedef enum logic {
        S_IDLE,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic signed [RW-1:0] r_mem [2][4][4];
    logic [1:0]           r_full;
    logic                 r_wbank;
    logic [1:0]           r_wrow;
    logic                 r_rbank;
    logic [1:0]           r_rrow;
    logic                 r_valid;
    logic                 r_last;
    logic [4*OWIDTH-1:0]  r_data;

    logic signed [RW-1:0]     w_x [4];
    logic signed [RW-1:0]     w_e;
    logic signed [RW-1:0]     w_f;
    logic signed [RW-1:0]     w_g;
    logic signed [RW-1:0]     w_h;
    logic signed [RW-1:0]     w_r [4];
    logic signed [OWIDTH-1:0] w_s [4][4];
    logic signed [OWIDTH-1:0] w_w [4];
    logic [4*OWIDTH-1:0]      w_col;
    logic                     w_wr;
    logic                     w_fill;
    logic                     w_hs;
    logic                     w_load;
    logic                     w_rdone;
    logic                     w_cbank;
    logic [1:0]               w_crow;

    assign READYI = (r_wrow != 2'd0) || !r_full[r_wbank];
    assign w_wr   = STROBEI && READYI;
    assign w_fill = w_wr && (r_wrow == 2'd3);
    assign w_hs   = r_valid && READYO;
    assign VALIDO = r_valid;
    assign DATAO  = r_data;
    assign LASTO  = r_last;

    // Row stage: butterfly on the incoming residual row
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            w_x[c] = RW'(signed'(DATAI[c*IWIDTH +: IWIDTH]));
        end
        w_e    = w_x[0] + w_x[3];
        w_f    = w_x[1] + w_x[2];
        w_g    = w_x[1] - w_x[2];
        w_h    = w_x[0] - w_x[3];
        w_r[0] = w_e + w_f;
        w_r[1] = (w_h <<< 1) + w_g;
        w_r[2] = w_e - w_f;
        w_r[3] = w_h - (w_g <<< 1);
    end

    always_ff @(posedge CLK) begin
        if (w_wr) begin
            for (int c = 0; c < 4; c++) begin
                r_mem[r_wbank][r_wrow][c] <= w_r[c];
            end
        end
    end

    // Column stage: coefficient row w_crow of bank w_cbank
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                w_s[k][c] = OWIDTH'(r_mem[w_cbank][k][c]);
            end
        end
        w_col = '0;
        for (int c = 0; c < 4; c++) begin
            w_w[c] = '0;
            unique case (w_crow)
                2'd0: w_w[c] = w_s[0][c] + w_s[1][c]
                             + w_s[2][c] + w_s[3][c];
                2'd1: w_w[c] = (w_s[0][c] <<< 1) + w_s[1][c]
                             - w_s[2][c] - (w_s[3][c] <<< 1);
                2'd2: w_w[c] = w_s[0][c] - w_s[1][c]
                             - w_s[2][c] + w_s[3][c];
                2'd3: w_w[c] = w_s[0][c] - (w_s[1][c] <<< 1)
                             + (w_s[2][c] <<< 1) - w_s[3][c];
            endcase
            w_col[c*OWIDTH +: OWIDTH] = w_w[c];
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_rdone    = 1'b0;
        w_cbank    = r_rbank;
        w_crow     = 2'd0;
        unique case (r_state)
            S_IDLE: begin
                if (r_full[r_rbank]) begin
                    w_load     = 1'b1;
                    w_state_nx = S_OUT;
                end
            end
            S_OUT: begin
                if (w_hs) begin
                    if (r_rrow == 2'd3) begin
                        w_rdone = 1'b1;
                        // Chain straight into the other bank to avoid a bubble
                        if (r_full[!r_rbank]) begin
                            w_load  = 1'b1;
                            w_cbank = !r_rbank;
                        end else begin
                            w_state_nx = S_IDLE;
                        end
                    end else begin
                        w_load = 1'b1;
                        w_crow = r_rrow + 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state <= S_IDLE;
            r_full  <= '0;
            r_wbank <= 1'b0;
            r_wrow  <= 2'd0;
            r_rbank <= 1'b0;
            r_rrow  <= 2'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_wr) begin
                r_wrow <= r_wrow + 2'd1;
            end
            if (w_fill) begin
                r_wbank         <= !r_wbank;
                r_full[r_wbank] <= 1'b1;
            end
            if (w_rdone) begin
                r_full[r_rbank] <= 1'b0;
                r_rbank         <= !r_rbank;
                r_rrow          <= 2'd0;
            end else if (w_hs) begin
                r_rrow <= r_rrow + 2'd1;
            end
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= w_col;
                r_last  <= (w_crow == 2'd3);
            end else if (w_hs) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

`ifdef H264_FT_NZCOUNT_EN
    logic [2:0] w_nz;
    logic [4:0] r_nzacc;
    logic [4:0] r_nzout;

    always_comb begin
        w_nz = '0;
        for (int c = 0; c < 4; c++) begin
            w_nz = w_nz + {2'b00, (w_w[c] != '0)};
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_nzacc <= '0;
            r_nzout <= '0;
        end else if (w_load) begin
            if (w_crow == 2'd0) begin
                r_nzacc <= 5'(w_nz);
            end else begin
                r_nzacc <= r_nzacc + 5'(w_nz);
            end
            if (w_crow == 2'd3) begin
                r_nzout <= r_nzacc + 5'(w_nz);
            end
        end
    end

    assign NZCOUNTO = r_nzout;
`endif

endmodule

// File: tb/tb_h264_fwd_transform4x4.sv
// Self-checking bench for h264_fwd_transform4x4: directed table, backpressure,
// reset and randomized blocks against a matrix-product reference model.
module tb_h264_fwd_transform4x4;

    logic        CLK;
    logic        RESETN;
    logic        STROBEI;
    logic [35:0] DATAI;
    logic        READYI;
    logic        VALIDO;
    logic [63:0] DATAO;
    logic        LASTO;
    logic        READYO;
`ifdef H264_FT_NZCOUNT_EN
    logic [4:0]  NZCOUNTO;
`endif

    h264_fwd_transform4x4 dut (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .STROBEI  (STROBEI),
        .DATAI    (DATAI),
        .READYI   (READYI),
        .VALIDO   (VALIDO),
        .DATAO    (DATAO),
        .LASTO    (LASTO),
        .READYO   (READYO)
`ifdef H264_FT_NZCOUNT_EN
        ,
        .NZCOUNTO (NZCOUNTO)
`endif
    );

    typedef logic [3:0][3:0][15:0] blk_t;

    typedef struct packed {
        blk_t       x;
        blk_t       w;
        logic [4:0] nz;
    } vec_t;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic [4:0]  nz;
    } exp_t;

    localparam int CM [4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2},
                                 '{1, -1, -1, 1}, '{1, -2, 2, -1}};

    int   checks;
    int   failures;
    vec_t vecs [5];
    exp_t exp_q [$];
    int   sgn [4];
    int   imp [4];
    int   ext_u [4];
    int   ext_v [4];
    blk_t b1, b2, b3;
    bit   rnd_done;

    logic [63:0] prev_d;
    logic        prev_l;
    logic [4:0]  prev_nz;
    bit          prev_stall;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", n, a, e, $time);
        end
    endtask

    function automatic logic [15:0] s16(input int v);
        return v[15:0];
    endfunction

    function automatic logic [35:0] pack_row(input logic [3:0][15:0] xr);
        logic [35:0] d;
        d = '0;
        for (int c = 0; c < 4; c++) d[c*9 +: 9] = xr[c][8:0];
        return d;
    endfunction

    // W = C * X * C^T with plain integer arithmetic
    function automatic blk_t model_block(input blk_t x);
        int   t [4][4];
        int   acc;
        blk_t w;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int m = 0; m < 4; m++)
                    acc += int'($signed(x[i][m])) * CM[j][m];
                t[i][j] = acc;
            end
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int i = 0; i < 4; i++) acc += CM[k][i] * t[i][j];
                w[k][j] = acc[15:0];
            end
        return w;
    endfunction

    function automatic logic [4:0] nz_of(input blk_t w);
        logic [4:0] n;
        n = '0;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++)
                if (w[k][j] != '0) n = n + 5'd1;
        return n;
    endfunction

    function automatic blk_t rand_block();
        blk_t x;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                x[i][j] = s16(int'($urandom_range(0, 511)) - 256);
        return x;
    endfunction

    task automatic push_exp(input blk_t w, input logic [4:0] nz);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.d  = w[k];
            e.l  = (k == 3);
            e.nz = nz;
            exp_q.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the last accepted row
    task automatic send_rows(input blk_t x, input int nrows);
        int wc;
        for (int r = 0; r < nrows; r++) begin
            wc = 0;
            while (!READYI && wc < 300) begin
                @(posedge CLK); #1;
                wc++;
            end
            if (!READYI) begin
                chk("readyi_timeout", 64'(READYI), 64'd1);
                return;
            end
            STROBEI = 1'b1;
            DATAI   = pack_row(x[r]);
            @(posedge CLK); #1;
            STROBEI = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge CLK); #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    always @(posedge CLK)
        if (RESETN && STROBEI)
            assert (READYI) else $error("protocol: STROBEI while READYI low");

    // Output monitor: scoreboard compare on handshakes, hold check on stalls
    always @(negedge CLK) begin
        exp_t e;
        if (!RESETN) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(VALIDO), 64'd1);
                chk("hold_data", DATAO, prev_d);
                chk("hold_last", 64'(LASTO), 64'(prev_l));
`ifdef H264_FT_NZCOUNT_EN
                chk("hold_nz", 64'(NZCOUNTO), 64'(prev_nz));
`endif
            end
            if (VALIDO && READYO) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_row", DATAO, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("row_data", DATAO, e.d);
                    chk("row_last", 64'(LASTO), 64'(e.l));
`ifdef H264_FT_NZCOUNT_EN
                    if (e.l) chk("row_nz", 64'(NZCOUNTO), 64'(e.nz));
`endif
                end
            end
            prev_stall = VALIDO && !READYO;
            prev_d     = DATAO;
            prev_l     = LASTO;
`ifdef H264_FT_NZCOUNT_EN
            prev_nz    = NZCOUNTO;
`else
            prev_nz    = '0;
`endif
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        STROBEI  = 1'b0;
        DATAI    = '0;
        READYO   = 1'b0;
        RESETN   = 1'b1;
        prev_stall = 1'b0;
        sgn   = '{1, 1, -1, -1};
        imp   = '{1, 2, 1, 1};
        ext_u = '{0, 6, 0, -2};
        ext_v = '{0, 1530, 0, -510};

        for (int i = 0; i < 5; i++) vecs[i] = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                vecs[1].x[r][c] = 16'd5;
                vecs[2].w[r][c] = s16(imp[r] * imp[c]);
                vecs[3].x[r][c] = s16(255 * sgn[r] * sgn[c]);
                vecs[3].w[r][c] = s16(ext_u[r] * ext_v[c]);
                vecs[4].x[r][c] = s16(-255 * sgn[r] * sgn[c]);
                vecs[4].w[r][c] = s16(-ext_u[r] * ext_v[c]);
            end
        vecs[1].w[0][0] = 16'd80;
        vecs[1].nz = 5'd1;
        vecs[2].x[0][0] = 16'd1;
        vecs[2].nz = 5'd16;
        vecs[3].nz = 5'd4;
        vecs[4].nz = 5'd4;

        #1 RESETN = 1'b0;
        #1;
        chk("rst_valid", 64'(VALIDO), 64'd0);
        chk("rst_last", 64'(LASTO), 64'd0);
        chk("rst_data", DATAO, 64'd0);
        chk("rst_readyi", 64'(READYI), 64'd1);
`ifdef H264_FT_NZCOUNT_EN
        chk("rst_nz", 64'(NZCOUNTO), 64'd0);
`endif
        repeat (2) @(posedge CLK);
        #1 RESETN = 1'b1;
        READYO = 1'b1;

        // Directed table, each block from an idle pipeline
        for (int v = 0; v < 5; v++) begin
            push_exp(vecs[v].w, vecs[v].nz);
            send_rows(vecs[v].x, 4);
            chk("lat_edge_e", 64'(VALIDO), 64'd0);
            @(posedge CLK); #1;
            chk("lat_edge_e1", 64'(VALIDO), 64'd1);
            chk("lat_row0", DATAO, 64'(vecs[v].w[0]));
            drain(100);
        end
        chk("ext_w11_pos", 64'(vecs[3].w[1][1]), 64'(s16(9180)));

        // Backpressure: three back-to-back blocks, sink stalled 12 cycles
        b1 = rand_block();
        b2 = rand_block();
        b3 = rand_block();
        push_exp(model_block(b1), nz_of(model_block(b1)));
        push_exp(model_block(b2), nz_of(model_block(b2)));
        push_exp(model_block(b3), nz_of(model_block(b3)));
        READYO = 1'b0;
        fork
            begin
                send_rows(b1, 4);
                send_rows(b2, 4);
                chk("bp_readyi_low", 64'(READYI), 64'd0);
                chk("bp_row0_held", DATAO, 64'(model_block(b1)));
                send_rows(b3, 4);
            end
            begin
                repeat (12) @(posedge CLK);
                #1 READYO = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    @(negedge CLK);
                    chk("bp_no_bubble", 64'(VALIDO), 64'd1);
                end
            end
        join
        drain(100);

        // Randomized blocks with random sink stalls
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 20; n++) begin
                    blk_t x;
                    x = rand_block();
                    push_exp(model_block(x), nz_of(model_block(x)));
                    send_rows(x, 4);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge CLK); #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    READYO = 1'($urandom_range(0, 1));
                    @(posedge CLK); #1;
                end
                READYO = 1'b1;
            end
        join
        drain(300);

        // Reset in the middle of a block with a stalled output pending
        READYO = 1'b0;
        send_rows(vecs[2].x, 4);
        repeat (2) begin
            @(posedge CLK); #1;
        end
        chk("rst_pre_valid", 64'(VALIDO), 64'd1);
        send_rows(vecs[1].x, 3);
        #2 RESETN = 1'b0;
        #1;
        chk("midrst_valid", 64'(VALIDO), 64'd0);
        chk("midrst_data", DATAO, 64'd0);
        chk("midrst_last", 64'(LASTO), 64'd0);
        chk("midrst_readyi", 64'(READYI), 64'd1);
        exp_q.delete();
        @(posedge CLK); #1;
        RESETN = 1'b1;
        READYO = 1'b1;
        push_exp(vecs[2].w, vecs[2].nz);
        send_rows(vecs[2].x, 4);
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
